// File: rtl/eth_tx_pkg.sv
// Shared constants, state encoding and helpers for the GMII transmit framer.
package eth_tx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StSfd  = 3'd2,
        StData = 3'd3,
        StPad  = 3'd4,
        StFcs  = 3'd5,
        StIfg  = 3'd6
    } tx_state_e;

    // Bit-reverses a 32-bit word; turns the normal polynomial into its reflected form.
    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one data byte.
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] PolyRefl = bit_reverse32(CRC32_POLY);

    // Shift the byte in LSB first through the reflected polynomial.
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ PolyRefl) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, zero padding, optional FCS append
// and inter-frame gap. Define GMII_TX_FCS_EN to generate and append the CRC-32;
// without it the upstream payload is expected to carry its own FCS.
module gmii_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_CYCLES   = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [10:0] PreCnt  = 11'(PREAMBLE_LEN);
    localparam logic [10:0] MinCnt  = 11'(MIN_FRAME);
    localparam logic [10:0] IfgLast = 11'(IFG_CYCLES - 1);

    tx_state_e   state;
    logic [10:0] cnt;      // preamble, payload/pad, FCS or IFG count depending on state
    logic [10:0] cnt_inc;
    logic        accept;

    assign s_ready = (state == StSfd) || (state == StData);
    assign accept  = s_valid && s_ready;
    assign busy    = (state != StIdle);
    // Byte count including the byte moving this cycle, pinned at MIN_FRAME.
    assign cnt_inc = (cnt < MinCnt) ? cnt + 11'd1 : cnt;

`ifdef GMII_TX_FCS_EN
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [7:0]  crc_din;
    logic [7:0]  fcs_byte;

    assign crc_din  = (state == StPad) ? 8'h00 : s_data;
    assign fcs      = ~crc;
    assign fcs_byte = fcs[{cnt[1:0], 3'b000} +: 8];

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc),
        .data    (crc_din),
        .crc_out (crc_next)
    );

    // CRC register: seeded while the preamble plays, advanced on each payload or pad byte.
    always_ff @(posedge gmii_tx_clk) begin
        if (!rst_n) begin
            crc <= CRC32_INIT;
        end else if (state == StPre) begin
            crc <= CRC32_INIT;
        end else if (accept || (state == StPad)) begin
            crc <= crc_next;
        end
    end
`endif

    // Framing FSM with registered GMII outputs and status pulses.
    always_ff @(posedge gmii_tx_clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            unique case (state)
                StIdle: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    // The waiting byte is not consumed; it goes out after the SFD.
                    if (s_valid) begin
                        state      <= StPre;
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= PREAMBLE_BYTE;
                        cnt        <= 11'd1;
                    end
                end
                StPre: begin
                    if (cnt == PreCnt) begin
                        gmii_txd <= SFD_BYTE;
                        state    <= StSfd;
                        cnt      <= '0;
                    end else begin
                        gmii_txd <= PREAMBLE_BYTE;
                        cnt      <= cnt + 11'd1;
                    end
                end
                StSfd, StData: begin
                    if (accept) begin
                        gmii_txd <= s_data;
                        cnt      <= cnt_inc;
                        state    <= StData;
                        if (s_last) begin
                            if (cnt_inc < MinCnt) begin
                                state <= StPad;
                            end else begin
`ifdef GMII_TX_FCS_EN
                                state <= StFcs;
                                cnt   <= '0;
`else
                                state      <= StIfg;
                                cnt        <= '0;
                                frame_done <= 1'b1;
`endif
                            end
                        end
                    end else begin
                        // Source starved mid-frame: cut the frame, no FCS.
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= 8'h00;
                        underrun   <= 1'b1;
                        state      <= StIfg;
                        cnt        <= '0;
                    end
                end
                StPad: begin
                    gmii_txd <= 8'h00;
                    cnt      <= cnt_inc;
                    if (cnt_inc == MinCnt) begin
`ifdef GMII_TX_FCS_EN
                        state <= StFcs;
                        cnt   <= '0;
`else
                        state      <= StIfg;
                        cnt        <= '0;
                        frame_done <= 1'b1;
`endif
                    end
                end
`ifdef GMII_TX_FCS_EN
                StFcs: begin
                    gmii_txd <= fcs_byte;
                    cnt      <= cnt + 11'd1;
                    if (cnt[1:0] == 2'd3) begin
                        frame_done <= 1'b1;
                        state      <= StIfg;
                        cnt        <= '0;
                    end
                end
`endif
                StIfg: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    cnt        <= cnt + 11'd1;
                    if (cnt == IfgLast) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state      <= StIdle;
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: a reference model builds each expected wire
// frame from the payload; a negedge monitor pops and compares what the DUT drives.
module tb_gmii_tx_framer;

    localparam int MinFrame = 60;
    localparam int IfgCycles = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] pl[$];         // payload of the frame being sent
    logic [7:0] exp_bytes[$];  // expected wire bytes, all queued frames back to back
    int         exp_len[$];
    bit         exp_under[$];
    int         exp_gap[$];    // required idle cycles before the frame, -1 = don't care

    bit         mon_en = 1'b1;
    bit         in_frame = 1'b0;
    int         gap_cnt = -1;
    int         nbytes = 0;
    int         cur_len = 0;
    int         cur_gap = -1;
    bit         cur_under = 1'b0;
    logic [7:0] eb;

    gmii_tx_framer dut (
        .gmii_tx_clk (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: preamble, SFD, payload, zero pad to MinFrame, optional CRC-32.
    function automatic void push_exp(input int n, input bit under, input int gap);
        logic [7:0]  f[$];
        logic [31:0] c;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 0; i < n; i++) f.push_back(pl[i]);
        if (!under) begin
            while (f.size() < 8 + MinFrame) f.push_back(8'h00);
`ifdef GMII_TX_FCS_EN
            c = 32'hFFFFFFFF;
            for (int i = 8; i < f.size(); i++) begin
                for (int b = 0; b < 8; b++) begin
                    if (c[0] ^ f[i][b]) c = (c >> 1) ^ 32'hEDB88320;
                    else c = c >> 1;
                end
            end
            c = ~c;
            for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
`endif
        end
        exp_len.push_back(f.size());
        exp_under.push_back(under);
        exp_gap.push_back(gap);
        foreach (f[i]) exp_bytes.push_back(f[i]);
    endfunction

    // Monitor: compares every tx_en byte against the scoreboard.
    always @(negedge clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
            gap_cnt  = -1;
        end else if (gmii_tx_en) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                nbytes   = 0;
                if (exp_len.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    cur_len = 0; cur_under = 1'b0; cur_gap = -1;
                end else begin
                    cur_len   = exp_len.pop_front();
                    cur_under = exp_under.pop_front();
                    cur_gap   = exp_gap.pop_front();
                    if (cur_gap >= 0 && gap_cnt >= 0) chk("ifg_gap", gap_cnt, cur_gap);
                end
            end
            if (nbytes < cur_len) begin
                eb = exp_bytes.pop_front();
                chk("txd", gmii_txd, eb);
            end else begin
                chk("extra_byte", 1, 0);
            end
            nbytes++;
            chk("frame_done", frame_done, (!cur_under && nbytes == cur_len));
        end else begin
            if (in_frame) begin
                in_frame = 1'b0;
                chk("frame_len", nbytes, cur_len);
                chk("underrun", underrun, cur_under);
                while (nbytes < cur_len) begin
                    eb = exp_bytes.pop_front();
                    nbytes++;
                end
                gap_cnt = 1;
            end else if (gap_cnt >= 0) begin
                gap_cnt++;
            end
        end
    end

    // Drives pl[0..stop_after-1]; hold keeps s_valid asserted afterwards.
    task automatic send_frame(input int n, input int stop_after, input bit hold);
        int   i = 0;
        int   waited = 0;
        logic acc;
        while (i < stop_after) begin
            s_valid = 1'b1;
            s_data  = pl[i];
            s_last  = (i == n - 1);
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                waited = 0;
            end else begin
                waited++;
                if (waited > 200) begin
                    chk("send_timeout", 1, 0);
                    break;
                end
            end
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_len.size() != 0 || in_frame || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", (k >= 3000), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int n;
        int idle;
        int gap;
        bit b2b;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_en", gmii_tx_en, 0);
        chk("rst_txd", gmii_txd, 8'h00);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 60-byte counting frame.
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        push_exp(60, 1'b0, -1);
        send_frame(60, 60, 1'b0);
        wait_drain();

        // 1-byte frame: pads out to the minimum.
        pl.delete();
        pl.push_back(8'hAB);
        push_exp(1, 1'b0, -1);
        send_frame(1, 1, 1'b0);
        wait_drain();

        // Two 64-byte frames back to back.
        fill_random(64);
        push_exp(64, 1'b0, -1);
        send_frame(64, 64, 1'b0);
        fill_random(64);
        push_exp(64, 1'b0, IfgCycles);
        send_frame(64, 64, 1'b0);
        wait_drain();

        // Underrun after 20 payload bytes, then a clean frame.
        fill_random(40);
        push_exp(20, 1'b1, -1);
        send_frame(40, 20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("underrun_s_ready", s_ready, 0);
        chk("underrun_busy", busy, 1);
        chk("underrun_tx_en", gmii_tx_en, 0);
        wait_drain();
        fill_random(45);
        push_exp(45, 1'b0, -1);
        send_frame(45, 45, 1'b0);
        wait_drain();

        // Reset pulse mid-payload truncates at once.
        mon_en = 1'b0;
        fill_random(30);
        send_frame(30, 10, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        @(negedge clk);
        chk("midrst_tx_en", gmii_tx_en, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_done", frame_done, 0);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1;
        fill_random(50);
        push_exp(50, 1'b0, -1);
        send_frame(50, 50, 1'b0);
        wait_drain();

        // Random frames with short (back-to-back) or long idle between them.
        b2b = 1'b0;
        for (int f = 0; f < 12; f++) begin
            n = int'($urandom_range(1, 90));
            idle = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : 30;
            repeat (idle) @(posedge clk);
            if (idle > 0) #1;
            gap = (b2b && idle <= 8) ? IfgCycles : -1;
            fill_random(n);
            push_exp(n, 1'b0, gap);
            send_frame(n, n, 1'b0);
            b2b = 1'b1;
        end
        wait_drain();
        chk("end_busy", busy, 0);
        chk("end_tx_en", gmii_tx_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
